// File: rtl/tick_scheduler.sv
// tick_scheduler: two-state (IDLE/RUN) scheduler that emits active-low
// sample ticks every D clock cycles. It runs in single, burst or
// continuous mode.
// Optional feature macro: TICK_COUNT_EN adds the o_tick_count output and
// its saturating counter.
`timescale 1ns/1ps
module tick_scheduler #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_n,
  input  logic             i_stop_n,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_divider,
  input  logic [CNT_W-1:0] i_burst_len,
  output logic             o_sample_tick_n,
  output logic             o_busy,
  output logic             o_done_n
`ifdef TICK_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_tick_count
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0] M_BURST = 2'b01;
  localparam logic [1:0] M_CONT  = 2'b10;

  state_t           r_state, w_next;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic [CNT_W-1:0] r_blen, r_bcnt;
  logic             r_tick_n, r_done_n, r_busy;
  logic             w_accept, w_tick, w_done, w_wrap, w_last;
  logic [DIV_W-1:0] w_div_eff;
  logic [CNT_W-1:0] w_blen_eff;

  // Clamp run parameters at accept time so the run uses sane values
  assign w_div_eff  = (i_divider < DIV_W'(2)) ? DIV_W'(2) : i_divider;
  assign w_blen_eff = (i_burst_len == '0) ? CNT_W'(1) : i_burst_len;
  assign w_wrap     = (r_cnt == r_div - DIV_W'(1));
  assign w_last     = (r_bcnt == r_blen - CNT_W'(1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and per-edge event decode; stop wins over a coincident tick
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_tick   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_start_n && i_stop_n) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (!i_stop_n) begin
          w_next = S_IDLE;
        end else if (w_wrap) begin
          w_tick = 1'b1;
          if (r_mode == M_CONT) begin
            w_next = S_RUN;
          end else if (r_mode == M_BURST) begin
            if (w_last) begin
              w_done = 1'b1;
              w_next = S_IDLE;
            end
          end else begin
            // single mode, and the unused encoding 11
            w_done = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latched run parameters, period/burst counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode   <= '0;
      r_div    <= '0;
      r_blen   <= '0;
      r_cnt    <= '0;
      r_bcnt   <= '0;
      r_tick_n <= 1'b1;
      r_done_n <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_tick_n <= ~w_tick;
      r_done_n <= ~w_done;
      r_busy   <= (w_next == S_RUN);
      if (w_accept) begin
        r_mode <= i_mode;
        r_div  <= w_div_eff;
        r_blen <= w_blen_eff;
        r_cnt  <= '0;
        r_bcnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
        if (w_tick) r_bcnt <= r_bcnt + CNT_W'(1);
      end
    end
  end

  assign o_sample_tick_n = r_tick_n;
  assign o_done_n        = r_done_n;
  assign o_busy          = r_busy;

`ifdef TICK_COUNT_EN
  logic [CNT_W-1:0] r_tick_count;

  // Ticks since last start; saturates, holds while idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_tick_count <= '0;
    else if (w_accept)                r_tick_count <= '0;
    else if (w_tick && !(&r_tick_count)) r_tick_count <= r_tick_count + CNT_W'(1);
  end

  assign o_tick_count = r_tick_count;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler.
`timescale 1ns/1ps
module tb_tick_scheduler;
  logic       i_clk, i_rst_n, i_start_n, i_stop_n;
  logic [1:0] i_mode;
  logic [7:0] i_divider, i_burst_len;
  logic       o_sample_tick_n, o_busy, o_done_n;
`ifdef TICK_COUNT_EN
  logic [7:0] o_tick_count;
`endif

  int errs = 0;
  int checks = 0;

  // window monitor results
  int m_nt, m_nd, m_dj;
  int m_tp [0:7];

  tick_scheduler #(.DIV_W(8), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start_n(i_start_n), .i_stop_n(i_stop_n),
    .i_mode(i_mode), .i_divider(i_divider), .i_burst_len(i_burst_len),
    .o_sample_tick_n(o_sample_tick_n), .o_busy(o_busy), .o_done_n(o_done_n)
`ifdef TICK_COUNT_EN
    , .o_tick_count(o_tick_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Start request accepted at the next edge k; returns at k+1ns
  task automatic do_start(input logic [1:0] mode, input int div, input int blen);
    i_mode = mode; i_divider = 8'(div); i_burst_len = 8'(blen); i_start_n = 1'b0;
    @(posedge i_clk); #1;
    i_start_n = 1'b1;
  endtask

  // Watch n edges; record tick positions (edge index j after the call) and done pulses
  task automatic watch(input int n);
    m_nt = 0; m_nd = 0; m_dj = -1;
    for (int i = 0; i < 8; i++) m_tp[i] = -1;
    for (int j = 1; j <= n; j++) begin
      @(posedge i_clk); #1;
      if (!o_sample_tick_n) begin
        if (m_nt < 8) m_tp[m_nt] = j;
        m_nt++;
      end
      if (!o_done_n) begin m_nd++; m_dj = j; end
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start_n = 1'b1; i_stop_n = 1'b1;
    i_mode = 2'b00; i_divider = 8'd0; i_burst_len = 8'd0;
    #12;
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_sample_tick_n !== 1'b1) begin errs++; $display("FAIL reset_tick: got %b expected 1", o_sample_tick_n); end
    checks++; if (o_done_n !== 1'b1) begin errs++; $display("FAIL reset_done: got %b expected 1", o_done_n); end
`ifdef TICK_COUNT_EN
    checks++; if (o_tick_count !== 8'd0) begin errs++; $display("FAIL reset_count: got %0d expected 0", o_tick_count); end
`endif
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_single;
    do_start(2'b00, 20, 0);
    checks++; if (o_busy !== 1'b1) begin errs++; $display("FAIL single_busy_on: got %b expected 1", o_busy); end
    watch(25);
    checks++; if (m_nt != 1) begin errs++; $display("FAIL single_ntick: got %0d expected 1", m_nt); end
    checks++; if (m_tp[0] != 20) begin errs++; $display("FAIL single_tick_pos: got %0d expected 20", m_tp[0]); end
    checks++; if (m_nd != 1 || m_dj != 20) begin errs++; $display("FAIL single_done: got n=%0d at %0d expected n=1 at 20", m_nd, m_dj); end
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL single_busy_off: got %b expected 0", o_busy); end
  endtask

  task automatic test_burst;
    do_start(2'b01, 40, 3);
    watch(130);
    checks++; if (m_nt != 3) begin errs++; $display("FAIL burst_ntick: got %0d expected 3", m_nt); end
    checks++; if (m_tp[0] != 40 || m_tp[1] != 80 || m_tp[2] != 120) begin
      errs++; $display("FAIL burst_tick_pos: got %0d %0d %0d expected 40 80 120", m_tp[0], m_tp[1], m_tp[2]); end
    checks++; if (m_nd != 1 || m_dj != 120) begin errs++; $display("FAIL burst_done: got n=%0d at %0d expected n=1 at 120", m_nd, m_dj); end
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL burst_busy_off: got %b expected 0", o_busy); end
`ifdef TICK_COUNT_EN
    checks++; if (o_tick_count !== 8'd3) begin errs++; $display("FAIL burst_count: got %0d expected 3", o_tick_count); end
`endif
  endtask

  task automatic test_stop;
    do_start(2'b10, 80, 0);
    watch(159);
    checks++; if (m_nt != 1 || m_tp[0] != 80) begin errs++; $display("FAIL cont_first_tick: got n=%0d at %0d expected n=1 at 80", m_nt, m_tp[0]); end
    checks++; if (o_busy !== 1'b1) begin errs++; $display("FAIL cont_busy: got %b expected 1", o_busy); end
    // edge 160 has counter 79: stop must suppress the tick
    i_stop_n = 1'b0;
    @(posedge i_clk); #1;
    i_stop_n = 1'b1;
    checks++; if (o_sample_tick_n !== 1'b1) begin errs++; $display("FAIL stop_tick: got %b expected 1", o_sample_tick_n); end
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL stop_busy: got %b expected 0", o_busy); end
    checks++; if (o_done_n !== 1'b1) begin errs++; $display("FAIL stop_done: got %b expected 1", o_done_n); end
    watch(5);
    checks++; if (m_nt != 0 || m_nd != 0) begin errs++; $display("FAIL stop_quiet: got ticks=%0d dones=%0d expected 0 0", m_nt, m_nd); end
`ifdef TICK_COUNT_EN
    checks++; if (o_tick_count !== 8'd1) begin errs++; $display("FAIL stop_count_hold: got %0d expected 1", o_tick_count); end
`endif
  endtask

  task automatic test_divider_min;
    do_start(2'b11, 0, 0);
    watch(6);
    checks++; if (m_nt != 1 || m_tp[0] != 2) begin errs++; $display("FAIL div0_tick: got n=%0d at %0d expected n=1 at 2", m_nt, m_tp[0]); end
    checks++; if (m_nd != 1 || m_dj != 2) begin errs++; $display("FAIL div0_done: got n=%0d at %0d expected n=1 at 2", m_nd, m_dj); end
    do_start(2'b01, 1, 0);
    watch(6);
    checks++; if (m_nt != 1 || m_tp[0] != 2) begin errs++; $display("FAIL div1_blen0_tick: got n=%0d at %0d expected n=1 at 2", m_nt, m_tp[0]); end
    checks++; if (m_nd != 1 || m_dj != 2) begin errs++; $display("FAIL div1_blen0_done: got n=%0d at %0d expected n=1 at 2", m_nd, m_dj); end
  endtask

  task automatic test_start_stop_together;
    i_mode = 2'b10; i_divider = 8'd4; i_start_n = 1'b0; i_stop_n = 1'b0;
    @(posedge i_clk); #1;
    i_start_n = 1'b1; i_stop_n = 1'b1;
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL start_stop_idle: got %b expected 0", o_busy); end
  endtask

  task automatic test_back_to_back;
    do_start(2'b10, 20, 0);
    watch(5);
    // new parameters and a start request while running must be ignored
    i_divider = 8'd80; i_mode = 2'b00; i_burst_len = 8'd1; i_start_n = 1'b0;
    watch(60);
    i_start_n = 1'b1;
    checks++; if (m_nt != 3) begin errs++; $display("FAIL ignore_ntick: got %0d expected 3", m_nt); end
    checks++; if (m_tp[0] != 15 || m_tp[2] != 55) begin errs++; $display("FAIL ignore_period: got %0d %0d expected 15 55", m_tp[0], m_tp[2]); end
    checks++; if (m_nd != 0) begin errs++; $display("FAIL ignore_done: got %0d expected 0", m_nd); end
    i_stop_n = 1'b0;
    @(posedge i_clk); #1;
    i_stop_n = 1'b1;
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL ignore_stop: got %b expected 0", o_busy); end
  endtask

  task automatic test_async_reset;
    do_start(2'b01, 40, 3);
    watch(50);
    checks++; if (m_nt != 1 || o_busy !== 1'b1) begin errs++; $display("FAIL areset_pre: got ticks=%0d busy=%b expected 1 1", m_nt, o_busy); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL areset_busy: got %b expected 0", o_busy); end
    checks++; if (o_sample_tick_n !== 1'b1 || o_done_n !== 1'b1) begin
      errs++; $display("FAIL areset_outs: got tick=%b done=%b expected 1 1", o_sample_tick_n, o_done_n); end
`ifdef TICK_COUNT_EN
    checks++; if (o_tick_count !== 8'd0) begin errs++; $display("FAIL areset_count: got %0d expected 0", o_tick_count); end
`endif
    i_mode = 2'b00; i_divider = 8'd4; i_burst_len = 8'd0; i_start_n = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    i_start_n = 1'b1;
    checks++; if (o_busy !== 1'b1) begin errs++; $display("FAIL areset_restart: got %b expected 1", o_busy); end
    watch(6);
    checks++; if (m_nt != 1 || m_tp[0] != 4) begin errs++; $display("FAIL areset_new_run: got n=%0d at %0d expected n=1 at 4", m_nt, m_tp[0]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_stop;
    test_divider_min;
    test_start_stop_together;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
